// File: rtl/dac_pkg.sv
// Shared constants for the unary MSB segment thermometer/DWA decoder.
// Latency: none (constants only).
// Backpressure: none (constants only).
package dac_pkg;

    // Default geometry of the unary segment: 3-bit code driving 6 cells.
    localparam int CODE_W_DEF = 3;
    localparam int N_ELEM_DEF = 6;

    // Selection between plain thermometer fill and rotating DWA fill.
    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_DWA    = 1'b1;

endpackage

// File: rtl/thermo_rot_mask.sv
// Rotated thermometer mask: k consecutive elements on, starting at element 'start', wrapping at N_ELEM.
// Latency: purely combinational.
// Backpressure: none; the result is a pure function of k and start.
module thermo_rot_mask #(
    parameter int CODE_W = 3,
    parameter int N_ELEM = 6,
    parameter int PTR_W  = $clog2(N_ELEM)
) (
    input  logic [CODE_W-1:0] k,
    input  logic [PTR_W-1:0]  start,
    output logic [N_ELEM-1:0] mask
);

    // Element i is on when its circular distance from start is below k.
    // Element i maps to mask bit N_ELEM-1-i, so element 0 is the MSB.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (i >= int'(start)) begin
                mask[N_ELEM-1-i] = (i - int'(start)) < int'(k);
            end else begin
                mask[N_ELEM-1-i] = (i + N_ELEM - int'(start)) < int'(k);
            end
        end
    end

endmodule

// File: rtl/thermo_dwa_decoder.sv
// Registered binary-to-thermometer decoder for the unary DAC segment, with optional DWA rotation.
// Latency: 1 cycle from a consumed sample (en=1) to DataOut/valid/err/ptr.
// Backpressure: none; samples are taken whenever en=1, outputs hold while en=0.
module thermo_dwa_decoder #(
    parameter int CODE_W = dac_pkg::CODE_W_DEF,
    parameter int N_ELEM = dac_pkg::N_ELEM_DEF,
    parameter int PTR_W  = $clog2(N_ELEM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [CODE_W-1:0] s,
    output logic [N_ELEM-1:0] DataOut,
    output logic              valid,
    output logic              err,
    output logic [PTR_W-1:0]  ptr
);

    import dac_pkg::*;

    // N_ELEM must not exceed 2**CODE_W - 1 so every legal count is representable in s.
    localparam logic [CODE_W-1:0] N_CODE = CODE_W'(N_ELEM);
    localparam logic [PTR_W:0]    N_SUM  = (PTR_W+1)'(N_ELEM);

    logic              in_range;
    logic [CODE_W-1:0] k;
    logic [PTR_W-1:0]  start;
    logic [N_ELEM-1:0] mask;
    logic [PTR_W:0]    sum;
    logic [PTR_W-1:0]  ptr_next;

    // Out-of-range codes collapse to zero elements and raise err.
    assign in_range = (s <= N_CODE);
    assign k        = in_range ? s : '0;

    // Static fill always starts at element 0; DWA starts at the held pointer.
    assign start = (mode == MODE_DWA) ? ptr : '0;

    // Pointer advance modulo N_ELEM: k <= N_ELEM and ptr < N_ELEM, so one
    // conditional subtract on a PTR_W+1 wide sum is enough.
    assign sum      = (PTR_W+1)'(ptr) + (PTR_W+1)'(k);
    assign ptr_next = (sum >= N_SUM) ? PTR_W'(sum - N_SUM) : PTR_W'(sum);

    thermo_rot_mask #(
        .CODE_W (CODE_W),
        .N_ELEM (N_ELEM),
        .PTR_W  (PTR_W)
    ) u_mask (
        .k     (k),
        .start (start),
        .mask  (mask)
    );

    // Output and pointer registers; reset wins over a simultaneous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            DataOut <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            ptr     <= '0;
        end else if (en) begin
            DataOut <= mask;
            valid   <= 1'b1;
            err     <= ~in_range;
            if ((mode == MODE_DWA) && in_range) begin
                ptr <= ptr_next;
            end
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_thermo_dwa_decoder.sv
// Self-checking bench: 6-element and 8-element decoders against a behavioural model.
// Latency: model and DUT both update at the sampling edge; checks on the falling edge.
// Backpressure: not applicable.
module tb_thermo_dwa_decoder;

    logic       clk = 1'b0;
    logic       rst, en, mode;
    logic [2:0] s6;
    logic [3:0] s8;

    logic [5:0] d6;
    logic       v6, e6;
    logic [2:0] p6;
    logic [7:0] d8;
    logic       v8, e8;
    logic [2:0] p8;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    bit bal_on = 1'b0;

    always #5 clk = ~clk;

    thermo_dwa_decoder u_dut6 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s6),
        .DataOut(d6), .valid(v6), .err(e6), .ptr(p6)
    );

    thermo_dwa_decoder #(.CODE_W(4), .N_ELEM(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s8),
        .DataOut(d8), .valid(v8), .err(e8), .ptr(p8)
    );

    // ---------------- behavioural model ----------------
    // Turn on elements p, p+1, ..., p+k-1 (mod n); element e sits at bit n-1-e.
    function automatic logic [15:0] ref_mask(input int n, input int p, input int k);
        logic [15:0] m;
        m = '0;
        for (int j = 0; j < k; j++) m[n-1-((p+j)%n)] = 1'b1;
        return m;
    endfunction

    logic [5:0] m6_data;  logic m6_valid, m6_err;  int m6_ptr, m6_k, k6;
    logic [7:0] m8_data;  logic m8_valid, m8_err;  int m8_ptr, m8_k, k8;

    always @(posedge clk) begin
        if (rst) begin
            m6_data <= '0; m6_valid <= 1'b0; m6_err <= 1'b0; m6_ptr <= 0; m6_k <= 0;
            m8_data <= '0; m8_valid <= 1'b0; m8_err <= 1'b0; m8_ptr <= 0; m8_k <= 0;
        end else if (en) begin
            k6 = (int'(s6) <= 6) ? int'(s6) : 0;
            k8 = (int'(s8) <= 8) ? int'(s8) : 0;
            m6_k     <= k6;
            m8_k     <= k8;
            m6_data  <= 6'(ref_mask(6, mode ? m6_ptr : 0, k6));
            m8_data  <= 8'(ref_mask(8, mode ? m8_ptr : 0, k8));
            m6_valid <= 1'b1;
            m8_valid <= 1'b1;
            m6_err   <= (int'(s6) > 6);
            m8_err   <= (int'(s8) > 8);
            if (mode && int'(s6) <= 6) m6_ptr <= (m6_ptr + k6) % 6;
            if (mode && int'(s8) <= 8) m8_ptr <= (m8_ptr + k8) % 8;
        end else begin
            m6_valid <= 1'b0;
            m8_valid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    int cnt6[6];
    int cnt8[8];
    int cum6, cum8;

    function automatic int spread6();
        int mx = cnt6[0], mn = cnt6[0];
        foreach (cnt6[i]) begin
            if (cnt6[i] > mx) mx = cnt6[i];
            if (cnt6[i] < mn) mn = cnt6[i];
        end
        return mx - mn;
    endfunction

    function automatic int spread8();
        int mx = cnt8[0], mn = cnt8[0];
        foreach (cnt8[i]) begin
            if (cnt8[i] > mx) mx = cnt8[i];
            if (cnt8[i] < mn) mn = cnt8[i];
        end
        return mx - mn;
    endfunction

    // Every falling edge: all outputs against the model, plus the popcount and
    // usage-balance properties.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("d6 DataOut", 16'(d6), 16'(m6_data));
                chk("d6 valid",   16'(v6), 16'(m6_valid));
                chk("d6 err",     16'(e6), 16'(m6_err));
                chk("d6 ptr",     16'(p6), 16'(m6_ptr));
                chk("d8 DataOut", 16'(d8), 16'(m8_data));
                chk("d8 valid",   16'(v8), 16'(m8_valid));
                chk("d8 err",     16'(e8), 16'(m8_err));
                chk("d8 ptr",     16'(p8), 16'(m8_ptr));
                if (m6_valid) chk("d6 popcount", 16'($countones(d6)), 16'(m6_k));
                if (m8_valid) chk("d8 popcount", 16'($countones(d8)), 16'(m8_k));
                if (bal_on && v6) begin
                    for (int i = 0; i < 6; i++) cnt6[i] += int'(d6[i]);
                    cum6 += m6_k;
                    if (cum6 > 0 && cum6 % 6 == 0) chk("d6 balance>1", 16'(spread6() > 1), 16'(0));
                end
                if (bal_on && v8) begin
                    for (int i = 0; i < 8; i++) cnt8[i] += int'(d8[i]);
                    cum8 += m8_k;
                    if (cum8 > 0 && cum8 % 8 == 0) chk("d8 balance>1", 16'(spread8() > 1), 16'(0));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic e, input logic m,
                        input logic [2:0] sv, input logic [3:0] sv8);
        @(negedge clk);
        rst = r; en = e; mode = m; s6 = sv; s8 = sv8;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations for the 6-element decoder.
    task automatic lit(input string nm, input logic [5:0] ed, input logic ev,
                       input logic ee, input logic [2:0] ep);
        chk({nm, " DataOut"}, 16'(d6), 16'(ed));
        chk({nm, " valid"},   16'(v6), 16'(ev));
        chk({nm, " err"},     16'(e6), 16'(ee));
        chk({nm, " ptr"},     16'(p6), 16'(ep));
    endtask

    logic [5:0] st_tab [7] = '{6'b000000, 6'b100000, 6'b110000, 6'b111000,
                               6'b111100, 6'b111110, 6'b111111};
    logic [2:0] dwa_s  [5] = '{3'd2, 3'd3, 3'd3, 3'd6, 3'd0};
    logic [5:0] dwa_d  [5] = '{6'b110000, 6'b001110, 6'b110001, 6'b111111, 6'b000000};
    logic [2:0] dwa_p  [5] = '{3'd2, 3'd5, 3'd2, 3'd2, 3'd2};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; s6 = '0; s8 = '0;
        step(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk_on = 1'b1;
        lit("reset", 6'b000000, 1'b0, 1'b0, 3'd0);

        // Static sweep 0..6.
        for (int v = 0; v <= 6; v++) begin
            step(1'b0, 1'b1, 1'b0, 3'(v), 4'($urandom_range(0, 15)));
            lit($sformatf("static s=%0d", v), st_tab[v], 1'b1, 1'b0, 3'd0);
        end

        // Out of range, then recovery.
        step(1'b0, 1'b1, 1'b0, 3'd7, 4'd9);
        lit("oor s=7", 6'b000000, 1'b1, 1'b1, 3'd0);
        step(1'b0, 1'b1, 1'b0, 3'd3, 4'd3);
        lit("after oor s=3", 6'b111000, 1'b1, 1'b0, 3'd0);

        // DWA with wrap-around from ptr=0.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, dwa_s[i], 4'($urandom_range(0, 15)));
            lit($sformatf("dwa #%0d", i), dwa_d[i], 1'b1, 1'b0, dwa_p[i]);
        end

        // Hold with en=0, then mode switches keep the pointer.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            lit("hold", 6'b000000, 1'b0, 1'b0, 3'd2);
        end
        step(1'b0, 1'b1, 1'b0, 3'd2, 4'd2);
        lit("static mid-dwa", 6'b110000, 1'b1, 1'b0, 3'd2);
        step(1'b0, 1'b1, 1'b1, 3'd1, 4'd1);
        lit("dwa resume", 6'b001000, 1'b1, 1'b0, 3'd3);
        step(1'b0, 1'b1, 1'b1, 3'd2, 4'd2);
        lit("dwa to ptr5", 6'b000110, 1'b1, 1'b0, 3'd5);

        // Reset wins over a simultaneous sample.
        step(1'b1, 1'b1, 1'b1, 3'd4, 4'd4);
        lit("reset mid-op", 6'b000000, 1'b0, 1'b0, 3'd0);

        // Mixed random traffic, including illegal codes and occasional reset.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)));
        end

        // DWA-only legal traffic for the usage-balance property.
        step(1'b0, 1'b0, 1'b1, 3'd0, 4'd0);
        foreach (cnt6[i]) cnt6[i] = 0;
        foreach (cnt8[i]) cnt8[i] = 0;
        cum6 = 0;
        cum8 = 0;
        bal_on = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            step(1'b0, ($urandom_range(0, 4) != 0), 1'b1,
                 3'($urandom_range(0, 6)), 4'($urandom_range(0, 8)));
        end
        step(1'b0, 1'b0, 1'b1, 3'd0, 4'd0);
        @(negedge clk);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
